// File: rtl/br_mispred_pkg.sv
// Shared branch-recovery types: ROB ids with wrap bit, mispredict/flush packets, age compare.
package br_mispred_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int PC_W      = 32;
    localparam int USEQ_W    = 12;

    typedef struct packed {
        logic                 wrap;
        logic [ROB_IDX_W-1:0] idx;
    } t_rob_id;

    typedef struct packed {
        logic              valid;
        logic              ucbr;
        logic [PC_W-1:0]   restore_pc;
        logic [USEQ_W-1:0] restore_useq;
        t_rob_id           robid;
        logic              tkn;
    } t_br_mispred_pkt;

    typedef struct packed {
        logic              ucbr;
        logic [PC_W-1:0]   restore_pc;
        logic [USEQ_W-1:0] restore_useq;
        t_rob_id           robid;
    } t_br_flush_pkt;

    // Differing wrap bits mean b's pointer has wrapped past a's, so the larger idx is older.
    function automatic logic rob_older(input t_rob_id a, input t_rob_id b);
        return (a.wrap == b.wrap) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/br_mispred_ctl.sv
// Mispredict arbiter: tracks oldest outstanding branch mispredict, pulses a younger-uop kill,
// and holds a front-end redirect request until acknowledged.
module br_mispred_ctl
    import br_mispred_pkg::*;
#(
    parameter int COLLECT_CYC = 2,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  t_br_mispred_pkt br_mispred_ex0,
    input  t_rob_id         rob_head_robid,
    input  logic            rob_nuke,
    output logic            flush_req,
    output t_br_flush_pkt   flush_pkt,
    input  logic            flush_ack,
    output logic            kill_vld,
    output t_rob_id         kill_robid,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } t_bmc_state;

    localparam int COL_W = (COLLECT_CYC > 1) ? $clog2(COLLECT_CYC) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLLECT_CYC - 1);

    t_bmc_state       r_state, w_state_nxt;
    t_br_flush_pkt    r_cur, w_cur_nxt;
    t_br_flush_pkt    r_nxt, w_nxt_nxt;
    logic             r_nxt_vld, w_nxt_vld_nxt;
    logic [COL_W-1:0] r_col_cnt, w_col_cnt_nxt;
    logic             r_flush_req, w_flush_req_nxt;
    t_br_flush_pkt    r_flush_pkt, w_flush_pkt_nxt;
    logic             r_kill_vld, w_kill_vld_nxt;
    t_rob_id          r_kill_robid, w_kill_robid_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic          w_mp_vld;
    t_br_flush_pkt w_mp;
    logic          w_older_cur;
    logic          w_older_nxt;
    logic          w_beats_nxt;
    logic          w_accept;

    assign w_mp_vld    = br_mispred_ex0.valid && !rob_nuke;
    assign w_mp        = '{ucbr:         br_mispred_ex0.ucbr,
                           restore_pc:   br_mispred_ex0.restore_pc,
                           restore_useq: br_mispred_ex0.restore_useq,
                           robid:        br_mispred_ex0.robid};
    assign w_older_cur = rob_older(br_mispred_ex0.robid, r_cur.robid);
    assign w_older_nxt = rob_older(br_mispred_ex0.robid, r_nxt.robid);
    // While flushing, a new mispredict must beat both the in-flight redirect and any queued one.
    assign w_beats_nxt = w_mp_vld && w_older_cur && (!r_nxt_vld || w_older_nxt);

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_nxt_nxt       = r_nxt;
        w_nxt_vld_nxt   = r_nxt_vld;
        w_col_cnt_nxt   = r_col_cnt;
        w_flush_pkt_nxt = r_flush_pkt;
        w_accept        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_mp_vld) begin
                    w_cur_nxt     = w_mp;
                    w_accept      = 1'b1;
                    w_col_cnt_nxt = '0;
                    w_state_nxt   = S_PEND;
                end
            end
            S_PEND: begin
                if (w_mp_vld && w_older_cur) begin
                    w_cur_nxt     = w_mp;
                    w_accept      = 1'b1;
                    w_col_cnt_nxt = '0;
                end else if (r_col_cnt == COL_LAST) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_pkt_nxt = r_cur;
                end else begin
                    w_col_cnt_nxt = r_col_cnt + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_ack) begin
                    w_nxt_vld_nxt = 1'b0;
                    w_col_cnt_nxt = '0;
                    if (w_beats_nxt) begin
                        w_cur_nxt   = w_mp;
                        w_accept    = 1'b1;
                        w_state_nxt = S_PEND;
                    end else if (r_nxt_vld) begin
                        w_cur_nxt   = r_nxt;
                        w_state_nxt = S_PEND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_beats_nxt) begin
                    w_nxt_nxt     = w_mp;
                    w_nxt_vld_nxt = 1'b1;
                    w_accept      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (rob_nuke) begin
            w_state_nxt     = S_IDLE;
            w_nxt_vld_nxt   = 1'b0;
            w_col_cnt_nxt   = '0;
            w_flush_pkt_nxt = r_flush_pkt;
        end

        w_flush_req_nxt  = (w_state_nxt == S_FLUSH);
        w_kill_vld_nxt   = w_accept;
        w_kill_robid_nxt = w_accept ? br_mispred_ex0.robid : r_kill_robid;
        w_cnt_nxt        = r_cnt + CNT_W'(w_accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_nxt        <= '0;
            r_nxt_vld    <= 1'b0;
            r_col_cnt    <= '0;
            r_flush_req  <= 1'b0;
            r_flush_pkt  <= '0;
            r_kill_vld   <= 1'b0;
            r_kill_robid <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur        <= w_cur_nxt;
            r_nxt        <= w_nxt_nxt;
            r_nxt_vld    <= w_nxt_vld_nxt;
            r_col_cnt    <= w_col_cnt_nxt;
            r_flush_req  <= w_flush_req_nxt;
            r_flush_pkt  <= w_flush_pkt_nxt;
            r_kill_vld   <= w_kill_vld_nxt;
            r_kill_robid <= w_kill_robid_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign flush_req   = r_flush_req;
    assign flush_pkt   = r_flush_pkt;
    assign kill_vld    = r_kill_vld;
    assign kill_robid  = r_kill_robid;
    assign mispred_cnt = r_cnt;
    assign o_dbg_state = r_state;

`ifndef SYNTHESIS
    // Redirect handshake: flush_req rises with a locked payload and holds it until flush_ack.
    a_pkt_stable: assert property (@(posedge clk) disable iff (reset)
        (flush_req && !flush_ack && !rob_nuke) |=> $stable(flush_pkt));
    a_ack_with_req: assert property (@(posedge clk) disable iff (reset)
        flush_ack |-> flush_req);
    a_not_before_head: assert property (@(posedge clk) disable iff (reset)
        br_mispred_ex0.valid |-> !rob_older(br_mispred_ex0.robid, rob_head_robid));
`endif

endmodule
